differentiator: RTL and testbench

DIFFERENTIATOR -- requirements
Module: differentiator

---
 rtl/differentiator_pkg.sv | 13 +
 rtl/differentiator_sat_shift.sv | 32 +++
 rtl/differentiator.sv | 83 ++++++++
 tb/tb_differentiator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/differentiator_pkg.sv
// Shared widths, clamp limits and FSM encoding for the sample differentiator.
package differentiator_pkg;
  localparam int W_DEF   = 18;
  localparam int DTW_DEF = 4;

  localparam int SAT_MAX = (2 ** (W_DEF - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (W_DEF - 1));

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;
endpackage

// File: rtl/differentiator_sat_shift.sv
// Combinational scale-and-clamp: value = clamp(diff <<< dt) into W signed bits.
module sat_shift
  import differentiator_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int DTW = DTW_DEF
) (
  input  logic signed [W:0]     diff,
  input  logic        [DTW-1:0] dt,
  output logic signed [W-1:0]   value,
  output logic                  sat
);
  // Wide enough that the largest shift of a W+1 bit difference never overflows.
  localparam int SW = W + (2 ** DTW);
  localparam logic signed [SW-1:0] HI = {{(SW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [SW-1:0] LO = {{(SW - W + 1){1'b1}}, {(W - 1){1'b0}}};

  logic signed [SW-1:0] scaled;

  always_comb begin
    scaled = SW'(diff) <<< dt;
    value  = scaled[W-1:0];
    sat    = 1'b0;
    if (scaled > HI) begin
      value = HI[W-1:0];
      sat   = 1'b1;
    end else if (scaled < LO) begin
      value = LO[W-1:0];
      sat   = 1'b1;
    end
  end
endmodule

// File: rtl/differentiator.sv
// First-difference differentiator with dt shift scaling, saturation and valid/ready flow control.
module differentiator
  import differentiator_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int DTW = DTW_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  restart,
  input  logic        [DTW-1:0] dt,
  input  logic signed [W-1:0]   x,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic signed [W-1:0]   dxdt,
  output logic                  sat,
  output logic                  out_valid,
  input  logic                  out_ready
);
  state_t              state_q, state_d;
  logic signed [W-1:0] x_prev_q, x_prev_d;
  logic signed [W-1:0] dxdt_q, dxdt_d;
  logic                sat_q, sat_d;
  logic                out_valid_q, out_valid_d;

  logic signed [W:0]   diff;
  logic signed [W-1:0] shift_value;
  logic                shift_sat;
  logic                accept;

  assign in_ready  = (!out_valid_q || out_ready) && !restart;
  assign accept    = in_valid && in_ready;
  assign diff      = $signed({x[W-1], x}) - $signed({x_prev_q[W-1], x_prev_q});
  assign dxdt      = dxdt_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;

  sat_shift #(.W(W), .DTW(DTW)) u_sat_shift (
    .diff  (diff),
    .dt    (dt),
    .value (shift_value),
    .sat   (shift_sat)
  );

  always_comb begin
    state_d     = state_q;
    x_prev_d    = x_prev_q;
    dxdt_d      = dxdt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q && !out_ready;
    if (restart) begin
      // Re-prime wins over any accept; a pending output is dropped.
      state_d     = PRIME;
      x_prev_d    = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      x_prev_d = x;
      if (state_q == PRIME) begin
        state_d = RUN;
      end else begin
        dxdt_d      = shift_value;
        sat_d       = shift_sat;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PRIME;
      x_prev_q    <= '0;
      dxdt_q      <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_prev_q    <= x_prev_d;
      dxdt_q      <= dxdt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_differentiator.sv
// Scoreboard bench for differentiator: directed samples push expected outputs, a monitor pops on handshake.
module tb_differentiator;
  import differentiator_pkg::*;

  logic                clock;
  logic                reset_n;
  logic                restart;
  logic [3:0]          dt;
  logic signed [17:0]  x;
  logic                in_valid;
  logic                in_ready;
  logic signed [17:0]  dxdt;
  logic                sat;
  logic                out_valid;
  logic                out_ready;

  typedef struct {
    logic signed [17:0] d;
    logic               s;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   checks = 0;
  int   errors = 0;
  int   cyc;

  differentiator #(.W(18), .DTW(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .restart   (restart),
    .dt        (dt),
    .x         (x),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dxdt      (dxdt),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Offers one sample (call at #1 after a rising edge); returns cycles until accepted.
  task automatic send(input int xv, input int dtv, input bit expv, input int expd,
                      input bit exps, output int ncyc);
    bit   acc;
    exp_t t;
    x        = 18'(xv);
    dt       = 4'(dtv);
    in_valid = 1'b1;
    acc      = 1'b0;
    ncyc     = 0;
    while (!acc && ncyc < 50) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      ncyc++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    else if (expv) begin
      t.d = 18'(expd);
      t.s = exps;
      sb.push_back(t);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", longint'(dxdt), 0);
        if (checks > 0) chk("unexpected_output_flag", 1, 0);
      end else begin
        got = sb.pop_front();
        chk("dxdt", longint'(dxdt), longint'(got.d));
        chk("sat", longint'(sat), longint'(got.s));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b1;
    restart   = 1'b0;
    dt        = '0;
    x         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_dxdt", longint'(dxdt), 0);
    chk("reset_sat", longint'(sat), 0);
    chk("reset_in_ready", longint'(in_ready), 1);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Basic and negative differences at dt=2.
    send(100, 2, 0, 0, 0, cyc);
    send(110, 2, 1, 40, 0, cyc);
    send(90, 2, 1, -80, 0, cyc);
    send(90, 2, 1, 0, 0, cyc);
    idle(2);

    // Positive saturation after a re-prime.
    restart = 1'b1;
    @(posedge clock);
    #1 restart = 1'b0;
    send(0, 9, 0, 0, 0, cyc);
    send(512, 9, 1, SAT_MAX, 1, cyc);
    idle(1);

    // Full-scale swing without wrap, then a large shift that stays in range.
    restart = 1'b1;
    @(posedge clock);
    #1 restart = 1'b0;
    send(SAT_MAX, 0, 0, 0, 0, cyc);
    send(SAT_MIN, 0, 1, SAT_MIN, 1, cyc);
    send(-131072, 0, 1, 0, 0, cyc);
    send(-131071, 15, 1, 32768, 0, cyc);
    idle(2);

    // Backpressure: the stalled sample carries the dt present when it is finally accepted.
    restart = 1'b1;
    @(posedge clock);
    #1 restart = 1'b0;
    send(1000, 1, 0, 0, 0, cyc);
    send(1010, 1, 1, 20, 0, cyc);
    out_ready = 1'b0;
    x         = 18'sd1030;
    dt        = 4'd7;
    in_valid  = 1'b1;
    repeat (5) begin
      @(negedge clock);
      chk("stall_in_ready", longint'(in_ready), 0);
      chk("stall_out_valid", longint'(out_valid), 1);
      chk("stall_dxdt_held", longint'(dxdt), 20);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    send(1030, 1, 1, 40, 0, cyc);
    chk("stream_cycles_a", cyc, 1);
    send(1030, 1, 1, 0, 0, cyc);
    chk("stream_cycles_b", cyc, 1);
    send(1000, 1, 1, -60, 0, cyc);
    chk("stream_cycles_c", cyc, 1);
    idle(2);

    // Restart discards a held output and blocks a concurrent sample.
    out_ready = 1'b0;
    send(1100, 1, 0, 0, 0, cyc);
    x        = 18'sd777;
    in_valid = 1'b1;
    restart  = 1'b1;
    @(negedge clock);
    chk("restart_in_ready", longint'(in_ready), 0);
    @(posedge clock);
    #1;
    restart  = 1'b0;
    in_valid = 1'b0;
    chk("restart_out_valid", longint'(out_valid), 0);
    out_ready = 1'b1;
    send(5000, 0, 0, 0, 0, cyc);
    send(5003, 0, 1, 3, 0, cyc);
    idle(2);

    // Asynchronous reset while an output is held.
    out_ready = 1'b0;
    send(5010, 0, 0, 0, 0, cyc);
    in_valid = 1'b0;
    chk("held_before_reset", longint'(dxdt), 7);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_out_valid", longint'(out_valid), 0);
    chk("async_dxdt", longint'(dxdt), 0);
    chk("async_sat", longint'(sat), 0);
    @(posedge clock);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    send(200, 0, 0, 0, 0, cyc);
    send(150, 0, 1, -50, 0, cyc);

    // Ramp of one LSB per sample, as an integrator with constant input would produce.
    send(0, 8, 1, -38400, 0, cyc);
    for (int i = 1; i <= 8; i++) send(i, 8, 1, 256, 0, cyc);
    in_valid = 1'b0;

    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(posedge clock);
      #1;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
